// File: rtl/select_seq_pkg.sv
// select_seq_pkg: shared definitions for the select_sequencer slice.
//   - SEL_W          width of the generated decoder select code
//   - MODE_*         step-order encodings for the mode input (2'b11 runs as up)
//   - state_t        sequencer FSM states
//   - step_t         result of one step: next code, bounce direction, wrap flag
//   - next_code()    pure step function shared by the sequencer datapath
package select_seq_pkg;

    localparam int SEL_W = 3;

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic             dir_down;
        logic             wrap;
    } step_t;

    // One step of the code sequence. dir_down only matters in bounce mode;
    // every other mode returns it cleared so leaving bounce restarts upward.
    function automatic step_t next_code(input logic [1:0]       mode,
                                        input logic [SEL_W-1:0] sel,
                                        input logic             dir_down);
        step_t r;
        r.sel      = sel;
        r.dir_down = 1'b0;
        r.wrap     = 1'b0;
        case (mode)
            MODE_DOWN: begin
                r.sel  = sel - 1'b1;
                r.wrap = (sel == 3'd0);
            end
            MODE_BOUNCE: begin
                // Turn around at the endpoints so 7 and 0 are not repeated.
                if (!dir_down) begin
                    if (sel == 3'd7) begin
                        r.sel      = 3'd6;
                        r.dir_down = 1'b1;
                    end else begin
                        r.sel = sel + 1'b1;
                    end
                end else begin
                    if (sel == 3'd0) begin
                        r.sel = 3'd1;
                    end else begin
                        r.sel      = sel - 1'b1;
                        r.dir_down = 1'b1;
                        r.wrap     = (sel == 3'd1);
                    end
                end
            end
            default: begin
                r.sel  = sel + 1'b1;
                r.wrap = (sel == 3'd7);
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/select_sequencer_dwell_timer.sv
// dwell_timer: loadable down-counter that times how long each code is held.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset (count clears to 0)
//   reload      load dwell into the counter (wins over enable)
//   enable      count down one this cycle; a zero count then expires
//   dwell       reload value
//   expire      combinational: enable high while the count is 0
module dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               reload,
    input  logic               enable,
    input  logic [DWELL_W-1:0] dwell,
    output logic               expire
);

    logic [DWELL_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (reload)
            cnt <= dwell;
        else if (enable && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expire = enable && (cnt == '0);

endmodule

// File: rtl/select_sequencer.sv
// select_sequencer: steps a 3-bit decoder select code in up, down or bounce
// order, holding each code for dwell+1 cycles, with start/stop/hold/load.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        IDLE -> RUN (ignored if stop is also high)
//   stop         RUN/HOLD -> IDLE; sel keeps its value
//   hold         level; freezes code and dwell count while high
//   load         one-cycle pulse; sel <= load_val in any state
//   load_val     code to load
//   mode         00 up, 01 down, 10 bounce, 11 up
//   dwell        each code is held dwell+1 cycles
//   sel          registered code to the decoder
//   sel_valid    high in RUN and HOLD
//   wrap         one-cycle pulse with the first code of a new pass
//   busy         high whenever not IDLE
//   onehot       (only with SELECT_SEQUENCER_ONEHOT_EN) registered 1<<sel
//                while valid, else 0
module select_sequencer
    import select_seq_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               hold,
    input  logic               load,
    input  logic [SEL_W-1:0]   load_val,
    input  logic [1:0]         mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic               wrap,
    output logic               busy
`ifdef SELECT_SEQUENCER_ONEHOT_EN
    ,
    output logic [7:0]         onehot
`endif
);

    state_t           state, state_nxt;
    logic             active;
    logic             do_stop, run_cycle, start_go;
    logic             reload, expire, step;
    logic [SEL_W-1:0] sel_nxt;
    logic             dir_down, dir_nxt;
    logic             wrap_nxt;
    step_t            stp;

    assign active   = (state != ST_IDLE);
    assign do_stop  = active && stop;
    assign start_go = (state == ST_IDLE) && start && !stop;
    // The counter advances on every active cycle where hold is low, including
    // the cycle that leaves HOLD, so each held cycle delays the step by exactly one.
    assign run_cycle = active && !stop && !load && !hold;
    assign step      = expire;
    assign reload    = (load && !do_stop) || step || start_go;

    dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .reload (reload),
        .enable (run_cycle),
        .dwell  (dwell),
        .expire (expire)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start && !stop) state_nxt = ST_RUN;
            ST_RUN: begin
                if (stop)      state_nxt = ST_IDLE;
                else if (hold) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (stop)       state_nxt = ST_IDLE;
                else if (!hold) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from the state register
    always_comb begin
        sel_valid = (state == ST_RUN) || (state == ST_HOLD);
        busy      = (state != ST_IDLE);
    end

    // Code datapath: stop > load > step
    always_comb begin
        stp      = next_code(mode, sel, dir_down);
        sel_nxt  = sel;
        dir_nxt  = (mode == MODE_BOUNCE) ? dir_down : 1'b0;
        wrap_nxt = 1'b0;
        if (do_stop) begin
            sel_nxt = sel;
        end else if (load) begin
            sel_nxt = load_val;
            dir_nxt = 1'b0;
        end else if (step) begin
            sel_nxt  = stp.sel;
            dir_nxt  = stp.dir_down;
            wrap_nxt = stp.wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel      <= '0;
            dir_down <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            sel      <= sel_nxt;
            dir_down <= dir_nxt;
            wrap     <= wrap_nxt;
        end
    end

`ifdef SELECT_SEQUENCER_ONEHOT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            onehot <= '0;
        else if (state_nxt != ST_IDLE)
            onehot <= 8'b1 << sel_nxt;
        else
            onehot <= '0;
    end
`endif

endmodule

// File: tb/tb_select_sequencer.sv
module tb_select_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, start, stop, hold, load;
    logic [2:0] load_val;
    logic [1:0] mode;
    logic [7:0] dwell;
    logic [2:0] sel;
    logic       sel_valid, wrap, busy;
`ifdef SELECT_SEQUENCER_ONEHOT_EN
    logic [7:0] onehot;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [2:0] exp_down   [1:15] = '{3'd3, 3'd3, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1,
                                      3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7, 3'd6};
    logic [2:0] exp_bounce [1:16] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6,
                                      3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};
    logic [2:0] exp_hold   [1:13] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1,
                                      3'd1, 3'd1, 3'd1, 3'd1, 3'd2};

    always #5 clk = ~clk;

    select_sequencer #(.DWELL_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .hold      (hold),
        .load      (load),
        .load_val  (load_val),
        .mode      (mode),
        .dwell     (dwell),
        .sel       (sel),
        .sel_valid (sel_valid),
        .wrap      (wrap),
        .busy      (busy)
`ifdef SELECT_SEQUENCER_ONEHOT_EN
        ,
        .onehot    (onehot)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0; load = 1'b0;
        load_val = 3'd0; mode = 2'b00; dwell = 8'd0;
        tick(); tick();
        if (sel !== 3'd0) begin tests_failed++; $display("FAIL reset sel: got %0d expected 0", sel); end
        tests_run++;
        if (sel_valid !== 1'b0) begin tests_failed++; $display("FAIL reset sel_valid: got %b expected 0", sel_valid); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset busy: got %b expected 0", busy); end
        tests_run++;
        if (wrap !== 1'b0) begin tests_failed++; $display("FAIL reset wrap: got %b expected 0", wrap); end
        tests_run++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_up();
        logic [2:0] e;
        dwell = 8'd0; mode = 2'b00; start = 1'b1;
        tick();
        start = 1'b0;
        chk("up first sel", sel, 0);
        chk("up sel_valid", sel_valid, 1);
        chk("up busy", busy, 1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            e = 3'(i % 8);
            if (sel !== e) begin tests_failed++; $display("FAIL up sel step %0d: got %0d expected %0d", i, sel, e); end
            tests_run++;
            if (wrap !== (i == 8)) begin tests_failed++; $display("FAIL up wrap step %0d: got %b expected %b", i, wrap, (i == 8)); end
            tests_run++;
`ifdef SELECT_SEQUENCER_ONEHOT_EN
            if (onehot !== (8'b1 << e)) begin tests_failed++; $display("FAIL up onehot step %0d: got %h expected %h", i, onehot, 8'b1 << e); end
            tests_run++;
`endif
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("up stop sel_valid", sel_valid, 0);
        chk("up stop busy", busy, 0);
    endtask

    task automatic test_down();
        dwell = 8'd2; mode = 2'b01; load_val = 3'd3; load = 1'b1;
        tick();
        load = 1'b0;
        chk("idle load sel", sel, 3);
        chk("idle load sel_valid", sel_valid, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("down first sel", sel, 3);
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (sel !== exp_down[k]) begin tests_failed++; $display("FAIL down sel k=%0d: got %0d expected %0d", k, sel, exp_down[k]); end
            tests_run++;
            if (wrap !== (k == 12)) begin tests_failed++; $display("FAIL down wrap k=%0d: got %b expected %b", k, wrap, (k == 12)); end
            tests_run++;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_bounce();
        load_val = 3'd0; load = 1'b1;
        tick();
        load = 1'b0;
        mode = 2'b10; dwell = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("bounce first sel", sel, 0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (sel !== exp_bounce[k]) begin tests_failed++; $display("FAIL bounce sel k=%0d: got %0d expected %0d", k, sel, exp_bounce[k]); end
            tests_run++;
            if (wrap !== (k == 14)) begin tests_failed++; $display("FAIL bounce wrap k=%0d: got %b expected %b", k, wrap, (k == 14)); end
            tests_run++;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_hold();
        load_val = 3'd0; load = 1'b1;
        tick();
        load = 1'b0;
        mode = 2'b00; dwell = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            hold = (k >= 6 && k <= 10);
            tick();
            if (sel !== exp_hold[k]) begin tests_failed++; $display("FAIL hold sel k=%0d: got %0d expected %0d", k, sel, exp_hold[k]); end
            tests_run++;
            if (sel_valid !== 1'b1) begin tests_failed++; $display("FAIL hold sel_valid k=%0d: got %b expected 1", k, sel_valid); end
            tests_run++;
        end
        hold = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("run stop sel_valid", sel_valid, 0);
        chk("run stop busy", busy, 0);
        chk("run stop sel kept", sel, 2);
    endtask

    task automatic test_start_stop_same();
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("start+stop busy", busy, 0);
        chk("start+stop sel_valid", sel_valid, 0);
        tick();
        chk("start+stop stays idle", busy, 0);
    endtask

    task automatic test_load_step_and_reset();
        dwell = 8'd0; mode = 2'b00; start = 1'b1;
        tick();
        start = 1'b0;
        chk("resume sel", sel, 2);
        load_val = 3'd6; load = 1'b1;
        tick();
        load = 1'b0;
        chk("load over step sel", sel, 6);
        chk("load no wrap", wrap, 0);
        chk("load keeps valid", sel_valid, 1);
        tick();
        chk("after load sel", sel, 7);
        tick();
        chk("after load wrap sel", sel, 0);
        chk("after load wrap", wrap, 1);
        for (int i = 0; i < 5; i++) tick();
        chk("pre-reset sel", sel, 5);
        rst_n = 1'b0; start = 1'b1;
        tick();
        chk("mid reset sel", sel, 0);
        chk("mid reset sel_valid", sel_valid, 0);
        chk("mid reset busy", busy, 0);
        chk("mid reset wrap", wrap, 0);
`ifdef SELECT_SEQUENCER_ONEHOT_EN
        chk("mid reset onehot", onehot, 0);
`endif
        rst_n = 1'b1; start = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_up();
        test_down();
        test_bounce();
        test_hold();
        test_start_stop_same();
        test_load_step_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
